// File: rtl/dcache_array_nway_pkg.sv
// Shared definitions for the N-way D-cache storage array.
//   - command opcode encoding
//   - flush-walker FSM state encoding
//   - derived address-field width helpers
package dcache_pkg;

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_REFILL = 2'd2;
   localparam logic [1:0] OP_FLUSH  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_WB   = 2'd2,
      ST_DONE = 2'd3
   } fsm_state_t;

   function automatic int off_w(input int block_bytes);
      return $clog2(block_bytes);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets, input int block_bytes);
      return addr_w - $clog2(sets) - $clog2(block_bytes);
   endfunction

endpackage

// File: rtl/dcache_array_nway_if.sv
// Command / response / eviction / flush write-back bundle between the
// D-cache controller (master) and the storage array (slave).
//   cmd_*    : ready/valid command port (op, inv, block address, byte enables, data)
//   resp_*   : one-cycle response pulse (hit, way, line data)
//   evict_*  : dirty victim reported alongside a REFILL response
//   wb_*     : flush write-back beats, ready/valid
interface dcache_array_nway_if
   import dcache_pkg::*;
#(
   parameter int WAYS        = 4,
   parameter int SETS        = 32,
   parameter int BLOCK_BYTES = 16,
   parameter int ADDR_W      = 32
) ();

   localparam int WAY_W  = $clog2(WAYS);
   localparam int BLK_W  = tag_w(ADDR_W, SETS, BLOCK_BYTES) + idx_w(SETS);
   localparam int LINE_W = 8 * BLOCK_BYTES;

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic                   cmd_inv;
   logic [BLK_W-1:0]       cmd_blk;
   logic [BLOCK_BYTES-1:0] cmd_be;
   logic [LINE_W-1:0]      cmd_data;

   logic                   resp_valid;
   logic                   resp_hit;
   logic [WAY_W-1:0]       resp_way;
   logic [LINE_W-1:0]      resp_data;

   logic                   evict_valid;
   logic [BLK_W-1:0]       evict_blk;
   logic [LINE_W-1:0]      evict_data;

   logic                   wb_valid;
   logic                   wb_ready;
   logic [BLK_W-1:0]       wb_blk;
   logic [LINE_W-1:0]      wb_data;

   modport master (
      output cmd_valid, cmd_op, cmd_inv, cmd_blk, cmd_be, cmd_data, wb_ready,
      input  cmd_ready, resp_valid, resp_hit, resp_way, resp_data,
             evict_valid, evict_blk, evict_data, wb_valid, wb_blk, wb_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_inv, cmd_blk, cmd_be, cmd_data, wb_ready,
      output cmd_ready, resp_valid, resp_hit, resp_way, resp_data,
             evict_valid, evict_blk, evict_data, wb_valid, wb_blk, wb_data
   );

endinterface

// File: rtl/dcache_array_nway_plru_tree.sv
// Tree pseudo-LRU helper for one set (purely combinational).
//   bits_i      : WAYS-1 tree bits, heap order (node n has children 2n+1, 2n+2)
//   touch_way_i : way being accessed
//   victim_o    : way reached by following the bits (0 = left, 1 = right)
//   bits_next_o : bits after touching touch_way_i (path bits point away from it)
module plru_tree #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-2:0]          bits_i,
   input  logic [$clog2(WAYS)-1:0]  touch_way_i,
   output logic [$clog2(WAYS)-1:0]  victim_o,
   output logic [WAYS-2:0]          bits_next_o
);

   localparam int LEVELS = $clog2(WAYS);
   localparam int WAY_W  = $clog2(WAYS);

   function automatic int node_level(input int n);
      int lv;
      lv = 0;
      for (int l = 0; l < LEVELS; l++) begin
         if (n >= (1 << l) - 1) lv = l;
      end
      return lv;
   endfunction

   // A node at level lv, position pos covers the ways whose top lv bits equal
   // pos. Nodes are visited in level order, so when a node is reached the
   // victim's upper bits are already final.
   always_comb begin : c_tree
      int vic;
      int tw;
      int lv;
      int pos;
      bits_next_o = bits_i;
      vic         = 0;
      tw          = int'(touch_way_i);
      lv          = 0;
      pos         = 0;
      for (int n = 0; n < WAYS - 1; n++) begin
         lv  = node_level(n);
         pos = n + 1 - (1 << lv);
         if ((vic >> (LEVELS - lv)) == pos) begin
            vic = vic | (int'(bits_i[n]) << (LEVELS - 1 - lv));
         end
         if ((tw >> (LEVELS - lv)) == pos) begin
            bits_next_o[n] = (((tw >> (LEVELS - 1 - lv)) & 1) == 0);
         end
      end
      victim_o = vic[WAY_W-1:0];
   end

endmodule

// File: rtl/dcache_array_nway.sv
// N-way set-associative D-cache data/tag array with tree-PLRU replacement,
// byte-masked write hits, refill with dirty-victim reporting and a
// flush/invalidate walker that emits write-back beats.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of dcache_array_nway_if (command, response, evict, wb)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | accepting LOOKUP/WRITE/REFILL/FLUSH, one per cycle
// ST_SCAN | flush walker examining line scan_q = {set, way}
// ST_WB   | holding a dirty line on wb_*, waiting for wb_ready
// ST_DONE | walk finished; emits the FLUSH response pulse
module dcache_array_nway
   import dcache_pkg::*;
#(
   parameter int WAYS        = 4,
   parameter int SETS        = 32,
   parameter int BLOCK_BYTES = 16,
   parameter int ADDR_W      = 32
) (
   input logic                clk,
   input logic                rst,
   dcache_array_nway_if.slave bus
);

   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, SETS, BLOCK_BYTES);
   localparam int BLK_W  = TAG_W + IDX_W;
   localparam int LINE_W = 8 * BLOCK_BYTES;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int SCAN_W = IDX_W + WAY_W;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [WAYS-2:0]   plru_q  [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];

   fsm_state_t        state_q;
   logic [SCAN_W-1:0] scan_q;
   logic              inv_q;

   logic              resp_valid_q;
   logic              resp_hit_q;
   logic [WAY_W-1:0]  resp_way_q;
   logic [LINE_W-1:0] resp_data_q;
   logic              evict_valid_q;
   logic [BLK_W-1:0]  evict_blk_q;
   logic [LINE_W-1:0] evict_data_q;
   logic              wb_valid_q;
   logic [BLK_W-1:0]  wb_blk_q;
   logic [LINE_W-1:0] wb_data_q;

   logic [IDX_W-1:0]  cmd_idx;
   logic [TAG_W-1:0]  cmd_tag;
   logic              cmd_acc;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              free;
   logic [WAY_W-1:0]  free_way;
   logic [WAY_W-1:0]  plru_victim;
   logic [WAYS-2:0]   plru_next;
   logic [WAY_W-1:0]  fill_way;
   logic [LINE_W-1:0] old_line;
   logic [TAG_W-1:0]  old_tag;
   logic              old_valid;
   logic              old_dirty;
   logic [LINE_W-1:0] merged;
   logic              line_wr;
   logic [LINE_W-1:0] new_line;

   logic [IDX_W-1:0]  scan_set;
   logic [WAY_W-1:0]  scan_way;
   logic              scan_last;

   assign cmd_idx   = bus.cmd_blk[IDX_W-1:0];
   assign cmd_tag   = bus.cmd_blk[BLK_W-1:IDX_W];
   assign cmd_acc   = bus.cmd_valid && (state_q == ST_IDLE);
   assign scan_set  = scan_q[SCAN_W-1:WAY_W];
   assign scan_way  = scan_q[WAY_W-1:0];
   assign scan_last = &scan_q;

   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[cmd_idx][w] && (tag_q[cmd_idx][w] == cmd_tag) && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[cmd_idx][w] && !free) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   // The same way is both the access target and the PLRU touch: the hit way
   // for LOOKUP/WRITE, the resident or replacement way for REFILL.
   assign fill_way = hit  ? hit_way :
                     free ? free_way : plru_victim;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits_i      (plru_q[cmd_idx]),
      .touch_way_i (fill_way),
      .victim_o    (plru_victim),
      .bits_next_o (plru_next)
   );

   assign old_line  = data_q[cmd_idx][fill_way];
   assign old_tag   = tag_q[cmd_idx][fill_way];
   assign old_valid = valid_q[cmd_idx][fill_way];
   assign old_dirty = dirty_q[cmd_idx][fill_way];

   always_comb begin
      merged = old_line;
      for (int b = 0; b < BLOCK_BYTES; b++) begin
         if (bus.cmd_be[b]) merged[8*b +: 8] = bus.cmd_data[8*b +: 8];
      end
   end

   assign line_wr  = cmd_acc && (((bus.cmd_op == OP_WRITE) && hit) || (bus.cmd_op == OP_REFILL));
   assign new_line = (bus.cmd_op == OP_WRITE) ? merged : bus.cmd_data;

   // Tag and data storage carry no reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (line_wr) begin
         data_q[cmd_idx][fill_way] <= new_line;
         if (bus.cmd_op == OP_REFILL) tag_q[cmd_idx][fill_way] <= cmd_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
         state_q       <= ST_IDLE;
         scan_q        <= '0;
         inv_q         <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_hit_q    <= 1'b0;
         resp_way_q    <= '0;
         resp_data_q   <= '0;
         evict_valid_q <= 1'b0;
         evict_blk_q   <= '0;
         evict_data_q  <= '0;
         wb_valid_q    <= 1'b0;
         wb_blk_q      <= '0;
         wb_data_q     <= '0;
      end else begin
         resp_valid_q  <= 1'b0;
         evict_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  case (bus.cmd_op)
                     OP_LOOKUP: begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit;
                        resp_way_q   <= hit ? hit_way : '0;
                        resp_data_q  <= hit ? old_line : '0;
                        if (hit) plru_q[cmd_idx] <= plru_next;
                     end
                     OP_WRITE: begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= hit;
                        resp_way_q   <= hit ? hit_way : '0;
                        resp_data_q  <= hit ? merged : '0;
                        if (hit) begin
                           dirty_q[cmd_idx][fill_way] <= 1'b1;
                           plru_q[cmd_idx]            <= plru_next;
                        end
                     end
                     OP_REFILL: begin
                        resp_valid_q               <= 1'b1;
                        resp_hit_q                 <= hit;
                        resp_way_q                 <= fill_way;
                        resp_data_q                <= bus.cmd_data;
                        valid_q[cmd_idx][fill_way] <= 1'b1;
                        dirty_q[cmd_idx][fill_way] <= 1'b0;
                        plru_q[cmd_idx]            <= plru_next;
                        if (!hit && old_valid && old_dirty) begin
                           evict_valid_q <= 1'b1;
                           evict_blk_q   <= {old_tag, cmd_idx};
                           evict_data_q  <= old_line;
                        end
                     end
                     default: begin
                        inv_q   <= bus.cmd_inv;
                        scan_q  <= '0;
                        state_q <= ST_SCAN;
                     end
                  endcase
               end
            end
            ST_SCAN: begin
               if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
                  wb_valid_q <= 1'b1;
                  wb_blk_q   <= {tag_q[scan_set][scan_way], scan_set};
                  wb_data_q  <= data_q[scan_set][scan_way];
                  state_q    <= ST_WB;
               end else begin
                  if (inv_q) valid_q[scan_set][scan_way] <= 1'b0;
                  if (scan_last) begin
                     state_q <= ST_DONE;
                  end else begin
                     scan_q <= scan_q + 1'b1;
                  end
               end
            end
            ST_WB: begin
               if (bus.wb_ready) begin
                  wb_valid_q                  <= 1'b0;
                  dirty_q[scan_set][scan_way] <= 1'b0;
                  if (inv_q) valid_q[scan_set][scan_way] <= 1'b0;
                  if (scan_last) begin
                     state_q <= ST_DONE;
                  end else begin
                     scan_q  <= scan_q + 1'b1;
                     state_q <= ST_SCAN;
                  end
               end
            end
            default: begin
               resp_valid_q <= 1'b1;
               resp_hit_q   <= 1'b0;
               resp_way_q   <= '0;
               resp_data_q  <= '0;
               if (inv_q) begin
                  for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
               end
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_hit    = resp_hit_q;
   assign bus.resp_way    = resp_way_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.evict_valid = evict_valid_q;
   assign bus.evict_blk   = evict_blk_q;
   assign bus.evict_data  = evict_data_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_blk      = wb_blk_q;
   assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_dcache_array_nway.sv
module tb_dcache_array_nway;
   import dcache_pkg::*;

   localparam int WAYS = 4;
   localparam int SETS = 8;
   localparam int BB   = 16;
   localparam int AW   = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dcache_array_nway_if #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB), .ADDR_W(AW)) bus ();

   dcache_array_nway #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]   op;
      logic [27:0]  blk;
      logic [15:0]  be;
      logic [127:0] data;
      logic         hit;
      logic [1:0]   way;
      logic [127:0] rdata;
      logic         ev;
      logic [27:0]  ev_blk;
      logic [127:0] ev_data;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [127:0] D0 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
   localparam logic [127:0] D1 = 128'h10111213_14151617_18191A1B_1C1D1E1F;
   localparam logic [127:0] D2 = 128'h20212223_24252627_28292A2B_2C2D2E2F;
   localparam logic [127:0] D3 = 128'h30313233_34353637_38393A3B_3C3D3E3F;
   localparam logic [127:0] D4 = 128'h40414243_44454647_48494A4B_4C4D4E4F;
   localparam logic [127:0] D5 = 128'h50515253_54555657_58595A5B_5C5D5E5F;
   localparam logic [127:0] D6 = 128'h60616263_64656667_68696A6B_6C6D6E6F;
   localparam logic [127:0] D7 = 128'h70717273_74757677_78797A7B_7C7D7E7F;
   localparam logic [127:0] W1 = 128'h10111213_14151617_18191A1B_DEADBEEF;
   localparam logic [127:0] E2 = 128'hE2E2E2E2_0BADC0DE_E2E2E2E2_12345678;
   localparam logic [127:0] M7 = 128'h70717273_74757677_CAFEF00D_7C7D7E7F;
   localparam logic [127:0] D5F = 128'h50515253_54555657_58595A5B_5C5D5EFF;

   function automatic logic [27:0] mb(input int tag, input int set);
      return 28'((tag << 3) | set);
   endfunction

   function automatic void add(input logic [1:0] op, input logic [27:0] b, input logic [15:0] be,
                               input logic [127:0] d, input logic h, input logic [1:0] w,
                               input logic [127:0] rd, input logic ev, input logic [27:0] eb,
                               input logic [127:0] ed);
      vecs.push_back('{op, b, be, d, h, w, rd, ev, eb, ed});
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         bus.cmd_op    = vecs[i].op;
         bus.cmd_blk   = vecs[i].blk;
         bus.cmd_be    = vecs[i].be;
         bus.cmd_data  = vecs[i].data;
         bus.cmd_inv   = 1'b0;
         bus.cmd_valid = 1'b1;
         chk($sformatf("v%0d.ready", i), 128'(bus.cmd_ready), 128'd1);
         @(posedge clk);
         #1;
         bus.cmd_valid = 1'b0;
         chk($sformatf("v%0d.resp_valid", i), 128'(bus.resp_valid), 128'd1);
         chk($sformatf("v%0d.hit", i), 128'(bus.resp_hit), 128'(vecs[i].hit));
         chk($sformatf("v%0d.way", i), 128'(bus.resp_way), 128'(vecs[i].way));
         chk($sformatf("v%0d.data", i), bus.resp_data, vecs[i].rdata);
         chk($sformatf("v%0d.evict_valid", i), 128'(bus.evict_valid), 128'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("v%0d.evict_blk", i), 128'(bus.evict_blk), 128'(vecs[i].ev_blk));
            chk($sformatf("v%0d.evict_data", i), bus.evict_data, vecs[i].ev_data);
         end
      end
   endtask

   task automatic start_flush(input logic inv);
      bus.cmd_op    = OP_FLUSH;
      bus.cmd_inv   = inv;
      bus.cmd_blk   = '0;
      bus.cmd_be    = '0;
      bus.cmd_data  = '0;
      bus.cmd_valid = 1'b1;
      chk("flush.ready_before", 128'(bus.cmd_ready), 128'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      chk("flush.busy", 128'(bus.cmd_ready), 128'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [27:0]  exp_wb_blk [2];
   logic [127:0] exp_wb_data[2];

   initial begin : main
      int p1, p2, p3, p4, p5;
      int cyc, beats, stall;
      logic got, saw_wb, found;
      logic [27:0]  cap_blk;
      logic [127:0] cap_data;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOOKUP;
      bus.cmd_inv   = 1'b0;
      bus.cmd_blk   = '0;
      bus.cmd_be    = '0;
      bus.cmd_data  = '0;
      bus.wb_ready  = 1'b0;

      // phase 1: fill, PLRU, write merge, dirty eviction
      add(OP_LOOKUP, 28'h010,   16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_REFILL, mb(0, 0),  16'h0000, D0, 1'b0, 2'd0, D0, 1'b0, '0, '0);
      add(OP_REFILL, mb(1, 0),  16'h0000, D1, 1'b0, 2'd1, D1, 1'b0, '0, '0);
      add(OP_REFILL, mb(2, 0),  16'h0000, D2, 1'b0, 2'd2, D2, 1'b0, '0, '0);
      add(OP_REFILL, mb(3, 0),  16'h0000, D3, 1'b0, 2'd3, D3, 1'b0, '0, '0);
      add(OP_REFILL, mb(4, 0),  16'h0000, D4, 1'b0, 2'd0, D4, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(1, 0),  16'h0000, '0, 1'b1, 2'd1, D1, 1'b0, '0, '0);
      add(OP_WRITE,  mb(1, 0),  16'h000F, 128'hDEADBEEF, 1'b1, 2'd1, W1, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(1, 0),  16'h0000, '0, 1'b1, 2'd1, W1, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(0, 0),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(2, 0),  16'h0000, '0, 1'b1, 2'd2, D2, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(4, 0),  16'h0000, '0, 1'b1, 2'd0, D4, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(3, 0),  16'h0000, '0, 1'b1, 2'd3, D3, 1'b0, '0, '0);
      add(OP_REFILL, mb(5, 0),  16'h0000, D5, 1'b0, 2'd1, D5, 1'b1, mb(1, 0), W1);
      add(OP_REFILL, mb(5, 0),  16'h0000, D6, 1'b1, 2'd1, D6, 1'b0, '0, '0);
      add(OP_WRITE,  mb(9, 0),  16'hFFFF, D0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_REFILL, mb(7, 1),  16'h0000, D7, 1'b0, 2'd0, D7, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(7, 1),  16'h0000, '0, 1'b1, 2'd0, D7, 1'b0, '0, '0);
      p1 = vecs.size();
      // phase 2: after clean flush, lines remain; then dirty two lines
      add(OP_LOOKUP, mb(5, 0),  16'h0000, '0, 1'b1, 2'd1, D6, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(7, 1),  16'h0000, '0, 1'b1, 2'd0, D7, 1'b0, '0, '0);
      add(OP_WRITE,  mb(2, 0),  16'hFFFF, E2, 1'b1, 2'd2, E2, 1'b0, '0, '0);
      add(OP_WRITE,  mb(7, 1),  16'h00F0, 128'h00000000_00000000_CAFEF00D_00000000,
          1'b1, 2'd0, M7, 1'b0, '0, '0);
      p2 = vecs.size();
      // phase 3: after invalidating flush everything misses
      add(OP_LOOKUP, mb(5, 0),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(2, 0),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(7, 1),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      add(OP_LOOKUP, mb(3, 0),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      p3 = vecs.size();
      // phase 4: one dirty line in set 2 for the reset-mid-flush case
      add(OP_REFILL, mb(5, 2),  16'h0000, D5, 1'b0, 2'd0, D5, 1'b0, '0, '0);
      add(OP_WRITE,  mb(5, 2),  16'h0001, 128'hFF, 1'b1, 2'd0, D5F, 1'b0, '0, '0);
      p4 = vecs.size();
      add(OP_LOOKUP, mb(5, 2),  16'h0000, '0, 1'b0, 2'd0, '0, 1'b0, '0, '0);
      p5 = vecs.size();

      exp_wb_blk[0]  = mb(2, 0);
      exp_wb_data[0] = E2;
      exp_wb_blk[1]  = mb(7, 1);
      exp_wb_data[1] = M7;

      // reset values
      #12;
      chk("rst.cmd_ready", 128'(bus.cmd_ready), 128'd1);
      chk("rst.resp_valid", 128'(bus.resp_valid), 128'd0);
      chk("rst.evict_valid", 128'(bus.evict_valid), 128'd0);
      chk("rst.wb_valid", 128'(bus.wb_valid), 128'd0);
      chk("rst.resp_data", bus.resp_data, 128'd0);
      chk("rst.evict_blk", 128'(bus.evict_blk), 128'd0);
      chk("rst.wb_blk", 128'(bus.wb_blk), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      apply(0, p1);
      @(posedge clk);
      #1;
      chk("pulse.resp_valid_low", 128'(bus.resp_valid), 128'd0);
      chk("pulse.evict_valid_low", 128'(bus.evict_valid), 128'd0);

      // clean flush without invalidate
      start_flush(1'b0);
      cyc = 0;
      got = 1'b0;
      saw_wb = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.wb_valid) saw_wb = 1'b1;
         if (bus.resp_valid) got = 1'b1;
      end
      chk("clean_flush.cycles", 128'(cyc), 128'(SETS * WAYS + 1));
      chk("clean_flush.no_wb", 128'(saw_wb), 128'd0);
      chk("clean_flush.resp_hit", 128'(bus.resp_hit), 128'd0);
      chk("clean_flush.ready_after", 128'(bus.cmd_ready), 128'd1);

      apply(p1, p2);

      // invalidating flush with two dirty lines and stalled write-backs
      start_flush(1'b1);
      cyc = 0;
      beats = 0;
      stall = 0;
      got = 1'b0;
      cap_blk = '0;
      cap_data = '0;
      bus.wb_ready = 1'b0;
      while (!got && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.wb_ready) begin
            bus.wb_ready = 1'b0;
            beats++;
            stall = 0;
         end
         if (bus.wb_valid) begin
            if (stall == 0) begin
               cap_blk  = bus.wb_blk;
               cap_data = bus.wb_data;
               chk("inv_flush.beat_expected", 128'(beats < 2), 128'd1);
               if (beats < 2) begin
                  chk($sformatf("inv_flush.wb%0d_blk", beats), 128'(bus.wb_blk), 128'(exp_wb_blk[beats]));
                  chk($sformatf("inv_flush.wb%0d_data", beats), bus.wb_data, exp_wb_data[beats]);
               end
            end else begin
               chk("inv_flush.blk_stable", 128'(bus.wb_blk), 128'(cap_blk));
               chk("inv_flush.data_stable", bus.wb_data, cap_data);
            end
            stall++;
            if (stall == 4) bus.wb_ready = 1'b1;
         end else if (stall != 0) begin
            chk("inv_flush.wb_dropped", 128'(bus.wb_valid), 128'd1);
            stall = 0;
         end
         if (bus.resp_valid) begin
            got = 1'b1;
            chk("inv_flush.beats_before_resp", 128'(beats), 128'd2);
            chk("inv_flush.resp_hit", 128'(bus.resp_hit), 128'd0);
            chk("inv_flush.cycles_min", 128'(cyc >= SETS * WAYS + 3), 128'd1);
         end
      end
      chk("inv_flush.resp_seen", 128'(got), 128'd1);
      bus.wb_ready = 1'b0;

      apply(p2, p3);
      apply(p3, p4);

      // reset while a write-back beat is pending
      start_flush(1'b0);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk);
         #1;
         if (bus.wb_valid) found = 1'b1;
      end
      chk("rst_flush.wb_seen", 128'(found), 128'd1);
      chk("rst_flush.wb_blk", 128'(bus.wb_blk), 128'(mb(5, 2)));
      chk("rst_flush.wb_data", bus.wb_data, D5F);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_flush.wb_valid_drop", 128'(bus.wb_valid), 128'd0);
      chk("rst_flush.cmd_ready", 128'(bus.cmd_ready), 128'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_flush.ready_after", 128'(bus.cmd_ready), 128'd1);
      apply(p4, p5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
